// File: rtl/fu_writeback_arbiter.sv
// Responder end of issue->execute: tracks in-flight FU ops, arbitrates scalar results onto
// the single regfile write port, pulses per-FU completion, and kills speculative ops on a miss.
module fu_writeback_arbiter #(
  parameter int unsigned NFU = 5,
  parameter int unsigned DW  = 32,
  parameter int unsigned RW  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NFU-1:0]    fu_en,
  input  logic [RW-1:0]     rd,
  input  logic              spec,
  input  logic              wen_req,
  input  logic [NFU-1:0]    fu_valid,
  input  logic [NFU*DW-1:0] fu_wdat,
  input  logic              branch_miss,
  input  logic              branch_resolved,
  output logic              wb_reg_en,
  output logic [RW-1:0]     wb_reg_sel,
  output logic [DW-1:0]     wb_wdat,
  output logic [NFU-1:0]    fu_ex,
  output logic [NFU-1:0]    busy,
  output logic              proto_err
);

  localparam int unsigned NSC = 3;  // FUs 0..NSC-1 may write a scalar register

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} fu_state_e;

  fu_state_e      state_q [NFU];
  fu_state_e      state_d [NFU];
  logic [RW-1:0]  rd_q    [NFU];
  logic [RW-1:0]  rd_d    [NFU];
  logic [DW-1:0]  data_q  [NFU];
  logic [DW-1:0]  data_d  [NFU];
  logic [NFU-1:0] wen_q, wen_d, spec_q, spec_d;

  logic           wb_en_d;
  logic [RW-1:0]  wb_sel_d;
  logic [DW-1:0]  wb_wdat_d;
  logic [NFU-1:0] fu_ex_d, busy_d;
  logic           perr_d;

  logic [NFU-1:0] kill, wr_cand, win, issue_sel, slot_free;
  logic           issue_multi;

  // Speculative kill and write-port candidacy per FU
  always_comb begin
    kill    = '0;
    wr_cand = '0;
    for (int unsigned i = 0; i < NFU; i++) begin
      kill[i] = branch_miss && spec_q[i] && (state_q[i] != IDLE);
      if ((i < NSC) && !kill[i])
        wr_cand[i] = (state_q[i] == HOLD) ||
                     ((state_q[i] == BUSY) && fu_valid[i] && wen_q[i] && (rd_q[i] != '0));
    end
  end

  // Fixed priority LD/ST > ALU > BRANCH
  always_comb begin
    win = '0;
    if (wr_cand[1])      win[1] = 1'b1;
    else if (wr_cand[0]) win[0] = 1'b1;
    else if (wr_cand[2]) win[2] = 1'b1;
  end

  assign issue_sel   = fu_en & (~fu_en + NFU'(1));
  assign issue_multi = (fu_en & (fu_en - NFU'(1))) != '0;

  // Per-FU next state, write port and completion pulses
  always_comb begin
    for (int unsigned i = 0; i < NFU; i++) begin
      state_d[i] = state_q[i];
      rd_d[i]    = rd_q[i];
      data_d[i]  = data_q[i];
    end
    wen_d     = wen_q;
    spec_d    = spec_q;
    wb_en_d   = 1'b0;
    wb_sel_d  = wb_reg_sel;
    wb_wdat_d = wb_wdat;
    fu_ex_d   = '0;
    busy_d    = '0;
    slot_free = '0;
    perr_d    = proto_err | issue_multi;

    for (int unsigned i = 0; i < NFU; i++) begin
      if (kill[i]) begin
        state_d[i]   = IDLE;
        spec_d[i]    = 1'b0;
        slot_free[i] = 1'b1;
      end else begin
        case (state_q[i])
          IDLE: begin
            slot_free[i] = 1'b1;
            if (fu_valid[i]) perr_d = 1'b1;
          end
          BUSY: begin
            if (fu_valid[i]) begin
              if (win[i]) begin
                wb_en_d      = 1'b1;
                wb_sel_d     = rd_q[i];
                wb_wdat_d    = fu_wdat[i*DW +: DW];
                fu_ex_d[i]   = 1'b1;
                state_d[i]   = IDLE;
                slot_free[i] = 1'b1;
              end else if (wr_cand[i]) begin
                data_d[i]  = fu_wdat[i*DW +: DW];
                state_d[i] = HOLD;
              end else begin
                fu_ex_d[i]   = 1'b1;
                state_d[i]   = IDLE;
                slot_free[i] = 1'b1;
              end
            end
          end
          HOLD: begin
            if (win[i]) begin
              wb_en_d      = 1'b1;
              wb_sel_d     = rd_q[i];
              wb_wdat_d    = data_q[i];
              fu_ex_d[i]   = 1'b1;
              state_d[i]   = IDLE;
              slot_free[i] = 1'b1;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end

      if (branch_resolved && !branch_miss) spec_d[i] = 1'b0;

      // A slot freed this cycle (retire, write or kill) may accept a new op
      if (issue_sel[i]) begin
        if (!slot_free[i]) begin
          perr_d = 1'b1;
        end else if (!(branch_miss && spec)) begin
          state_d[i] = BUSY;
          rd_d[i]    = rd;
          spec_d[i]  = spec && !branch_resolved;
          wen_d[i]   = wen_req && (i < NSC);
        end
      end

      busy_d[i] = (state_d[i] != IDLE);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NFU; i++) begin
        state_q[i] <= IDLE;
        rd_q[i]    <= '0;
        data_q[i]  <= '0;
      end
      wen_q      <= '0;
      spec_q     <= '0;
      wb_reg_en  <= 1'b0;
      wb_reg_sel <= '0;
      wb_wdat    <= '0;
      fu_ex      <= '0;
      busy       <= '0;
      proto_err  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NFU; i++) begin
        state_q[i] <= state_d[i];
        rd_q[i]    <= rd_d[i];
        data_q[i]  <= data_d[i];
      end
      wen_q      <= wen_d;
      spec_q     <= spec_d;
      wb_reg_en  <= wb_en_d;
      wb_reg_sel <= wb_sel_d;
      wb_wdat    <= wb_wdat_d;
      fu_ex      <= fu_ex_d;
      busy       <= busy_d;
      proto_err  <= perr_d;
    end
  end

endmodule

// File: tb/tb_fu_writeback_arbiter.sv
// Bench for fu_writeback_arbiter: directed scenarios plus randomized traffic checked
// every cycle against an op-level reference model.
module tb_fu_writeback_arbiter;
  localparam int NFU = 5;
  localparam int DW  = 32;
  localparam int RW  = 5;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NFU-1:0]    fu_en;
  logic [RW-1:0]     rd;
  logic              spec;
  logic              wen_req;
  logic [NFU-1:0]    fu_valid;
  logic [NFU*DW-1:0] fu_wdat;
  logic              branch_miss;
  logic              branch_resolved;
  logic              wb_reg_en;
  logic [RW-1:0]     wb_reg_sel;
  logic [DW-1:0]     wb_wdat;
  logic [NFU-1:0]    fu_ex;
  logic [NFU-1:0]    busy;
  logic              proto_err;

  fu_writeback_arbiter #(.NFU(NFU), .DW(DW), .RW(RW)) dut (
    .CLK(CLK), .RST(RST), .fu_en(fu_en), .rd(rd), .spec(spec), .wen_req(wen_req),
    .fu_valid(fu_valid), .fu_wdat(fu_wdat), .branch_miss(branch_miss),
    .branch_resolved(branch_resolved), .wb_reg_en(wb_reg_en), .wb_reg_sel(wb_reg_sel),
    .wb_wdat(wb_wdat), .fu_ex(fu_ex), .busy(busy), .proto_err(proto_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: one op slot per FU; has_res means a result waits for the write port
  bit            m_act  [NFU];
  bit            m_res  [NFU];
  bit            m_wen  [NFU];
  bit            m_spec [NFU];
  logic [RW-1:0] m_rd   [NFU];
  logic [DW-1:0] m_dat  [NFU];

  bit             e_en;
  logic [RW-1:0]  e_sel;
  logic [DW-1:0]  e_wdat;
  logic [NFU-1:0] e_ex;
  logic [NFU-1:0] e_busy;
  bit             e_perr;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  pri [3];
    bit  freed [NFU];
    bit  done;
    int  j;
    pri  = '{1, 0, 2};
    e_en = 1'b0;
    e_ex = '0;
    if (RST) begin
      for (int i = 0; i < NFU; i++) begin
        m_act[i] = 1'b0;
        m_res[i] = 1'b0;
      end
      e_sel  = '0;
      e_wdat = '0;
      e_busy = '0;
      e_perr = 1'b0;
      return;
    end
    // Kills first, then results arriving
    for (int i = 0; i < NFU; i++) begin
      freed[i] = !m_act[i];
      if (branch_miss && m_act[i] && m_spec[i]) begin
        m_act[i] = 1'b0;
        m_res[i] = 1'b0;
        freed[i] = 1'b1;
      end else if (fu_valid[i]) begin
        if (!m_act[i]) e_perr = 1'b1;
        else if (!m_res[i]) begin
          if (i < 3 && m_wen[i] && m_rd[i] != '0) begin
            m_res[i] = 1'b1;
            m_dat[i] = fu_wdat[i*DW +: DW];
          end else begin
            m_act[i] = 1'b0;
            e_ex[i]  = 1'b1;
            freed[i] = 1'b1;
          end
        end
      end
    end
    // One write per cycle, first waiting result in priority order
    done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      j = pri[k];
      if (!done && m_act[j] && m_res[j]) begin
        done     = 1'b1;
        e_en     = 1'b1;
        e_sel    = m_rd[j];
        e_wdat   = m_dat[j];
        e_ex[j]  = 1'b1;
        m_act[j] = 1'b0;
        m_res[j] = 1'b0;
        freed[j] = 1'b1;
      end
    end
    if (branch_resolved && !branch_miss)
      for (int i = 0; i < NFU; i++) m_spec[i] = 1'b0;
    if ($countones(fu_en) > 1) e_perr = 1'b1;
    done = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      if (!done && fu_en[i]) begin
        done = 1'b1;
        if (!freed[i]) e_perr = 1'b1;
        else if (!(branch_miss && spec)) begin
          m_act[i]  = 1'b1;
          m_res[i]  = 1'b0;
          m_rd[i]   = rd;
          m_wen[i]  = wen_req && (i < 3);
          m_spec[i] = spec && !branch_resolved;
        end
      end
    end
    for (int i = 0; i < NFU; i++) e_busy[i] = m_act[i];
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check("wb_reg_en", 64'(wb_reg_en), 64'(e_en));
    if (e_en) begin
      check("wb_reg_sel", 64'(wb_reg_sel), 64'(e_sel));
      check("wb_wdat", 64'(wb_wdat), 64'(e_wdat));
    end
    check("fu_ex", 64'(fu_ex), 64'(e_ex));
    check("busy", 64'(busy), 64'(e_busy));
    check("proto_err", 64'(proto_err), 64'(e_perr));
  endtask

  task automatic idle_in();
    fu_en           = '0;
    rd              = '0;
    spec            = 1'b0;
    wen_req         = 1'b0;
    fu_valid        = '0;
    fu_wdat         = '0;
    branch_miss     = 1'b0;
    branch_resolved = 1'b0;
  endtask

  task automatic issue(input int fu, input logic [RW-1:0] r, input bit w, input bit s);
    idle_in();
    fu_en[fu] = 1'b1;
    rd        = r;
    wen_req   = w;
    spec      = s;
    tick();
  endtask

  task automatic rand_cycle(input bit allow_err);
    int j;
    idle_in();
    fu_wdat = {$urandom, $urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 2) == 0) begin
      j = $urandom_range(0, NFU-1);
      if (allow_err || !m_act[j]) begin
        fu_en[j] = 1'b1;
        rd       = RW'($urandom);
        wen_req  = 1'($urandom);
        spec     = ($urandom_range(0, 3) == 0);
      end
    end
    if (allow_err && $urandom_range(0, 15) == 0) fu_en = NFU'($urandom);
    for (int i = 0; i < NFU; i++) begin
      if (m_act[i] && !m_res[i] && $urandom_range(0, 2) == 0) fu_valid[i] = 1'b1;
      else if (allow_err && !m_act[i] && $urandom_range(0, 30) == 0) fu_valid[i] = 1'b1;
    end
    branch_miss     = ($urandom_range(0, 24) == 0);
    branch_resolved = ($urandom_range(0, 9) == 0);
    tick();
  endtask

  initial begin
    idle_in();
    RST = 1'b1;
    tick();
    tick();
    check("rst_wb_reg_en", 64'(wb_reg_en), 64'd0);
    check("rst_wb_reg_sel", 64'(wb_reg_sel), 64'd0);
    check("rst_wb_wdat", 64'(wb_wdat), 64'd0);
    check("rst_fu_ex", 64'(fu_ex), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    RST = 1'b0;

    // ALU write, uncontended
    issue(0, 5'd5, 1'b1, 1'b0);
    check("t1_busy", 64'(busy), 64'h01);
    idle_in();
    tick();
    fu_valid[0] = 1'b1;
    fu_wdat[31:0] = 32'hDEADBEEF;
    tick();
    check("t1_en", 64'(wb_reg_en), 64'd1);
    check("t1_sel", 64'(wb_reg_sel), 64'd5);
    check("t1_wdat", 64'(wb_wdat), 64'hDEADBEEF);
    check("t1_ex", 64'(fu_ex), 64'h01);
    idle_in();
    tick();

    // ALU and LD/ST results collide: LD/ST first
    issue(0, 5'd3, 1'b1, 1'b0);
    issue(1, 5'd4, 1'b1, 1'b0);
    idle_in();
    fu_valid = 5'b00011;
    fu_wdat[31:0]  = 32'h33333333;
    fu_wdat[63:32] = 32'h44444444;
    tick();
    check("t2a_sel", 64'(wb_reg_sel), 64'd4);
    check("t2a_ex", 64'(fu_ex), 64'h02);
    idle_in();
    tick();
    check("t2b_sel", 64'(wb_reg_sel), 64'd3);
    check("t2b_wdat", 64'(wb_wdat), 64'h33333333);
    check("t2b_ex", 64'(fu_ex), 64'h01);
    tick();

    // GEMM retires without a write
    issue(4, 5'd9, 1'b1, 1'b0);
    idle_in();
    fu_valid[4] = 1'b1;
    tick();
    check("t3_ex", 64'(fu_ex), 64'h10);
    check("t3_en", 64'(wb_reg_en), 64'd0);
    idle_in();

    // Speculative ALU killed, non-speculative LD/ST survives
    issue(0, 5'd7, 1'b1, 1'b1);
    issue(1, 5'd8, 1'b1, 1'b0);
    idle_in();
    branch_miss = 1'b1;
    tick();
    check("t4_busy", 64'(busy), 64'h02);
    check("t4_ex", 64'(fu_ex), 64'h00);
    idle_in();
    fu_valid[1] = 1'b1;
    fu_wdat[63:32] = 32'h0000ABCD;
    tick();
    check("t4_sel", 64'(wb_reg_sel), 64'd8);
    check("t4_ex2", 64'(fu_ex), 64'h02);
    idle_in();
    tick();

    // rd == 0 never writes
    issue(0, 5'd0, 1'b1, 1'b0);
    idle_in();
    fu_valid[0] = 1'b1;
    tick();
    check("t5_ex", 64'(fu_ex), 64'h01);
    check("t5_en", 64'(wb_reg_en), 64'd0);
    idle_in();

    // Stray result pulse is sticky until reset
    fu_valid[2] = 1'b1;
    tick();
    check("t6_err", 64'(proto_err), 64'd1);
    idle_in();
    tick();
    tick();
    check("t6_sticky", 64'(proto_err), 64'd1);
    RST = 1'b1;
    tick();
    check("t6_rst", 64'(proto_err), 64'd0);
    RST = 1'b0;

    // Randomized legal traffic
    for (int n = 0; n < 400; n++) rand_cycle(1'b0);
    check("legal_no_err", 64'(proto_err), 64'd0);

    // Randomized traffic including protocol violations
    for (int n = 0; n < 250; n++) rand_cycle(1'b1);

    // Reset mid-operation suppresses the pending completion
    RST = 1'b1;
    idle_in();
    tick();
    RST = 1'b0;
    issue(0, 5'd9, 1'b1, 1'b0);
    idle_in();
    fu_valid[0] = 1'b1;
    RST = 1'b1;
    tick();
    check("rst_mid_en", 64'(wb_reg_en), 64'd0);
    check("rst_mid_ex", 64'(fu_ex), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    RST = 1'b0;
    idle_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
